// File: rtl/mem_map_pkg.sv
// Memory map shared by the bus controller and its address decoder:
// region and FSM state encodings, region bounds and the open-bus value.
package mem_map_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        RAM   = 3'd1,
        PIA   = 3'd2,
        BASIC = 3'd3,
        WOZ   = 3'd4
    } region_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [15:0] RAM_BASE    = 16'h0000;
    localparam logic [15:0] RAM_LIMIT   = 16'h1FFF;
    localparam logic [15:0] PIA_BASE    = 16'hD010;
    localparam logic [15:0] PIA_LIMIT   = 16'hD013;
    localparam logic [15:0] BASIC_BASE  = 16'hE000;
    localparam logic [15:0] BASIC_LIMIT = 16'hEFFF;
    localparam logic [15:0] WOZ_BASE    = 16'hFF00;
    localparam logic [15:0] WOZ_LIMIT   = 16'hFFFF;

    // Value returned for reads that hit no target
    localparam logic [7:0] OPEN_BUS_DATA = 8'hFF;

    // Largest wait-state count that fits the 4-bit counter
    localparam int unsigned WAIT_MAX = 15;

    // Inclusive address range test
    function automatic logic in_range(input logic [15:0] addr,
                                      input logic [15:0] base,
                                      input logic [15:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational CPU address decoder: maps a 16-bit address to a region.
module mem_addr_decode
    import mem_map_pkg::*;
#(
    parameter logic BASIC_EN = 1'b1
) (
    input  logic [15:0] cpu_addr,
    output region_t     region
);

    // Priority-free decode; the ranges do not overlap
    always_comb begin
        region = NONE;
        if (in_range(cpu_addr, RAM_BASE, RAM_LIMIT)) begin
            region = RAM;
        end else if (in_range(cpu_addr, PIA_BASE, PIA_LIMIT)) begin
            region = PIA;
        end else if (BASIC_EN && in_range(cpu_addr, BASIC_BASE, BASIC_LIMIT)) begin
            region = BASIC;
        end else if (in_range(cpu_addr, WOZ_BASE, WOZ_LIMIT)) begin
            region = WOZ;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU-side memory bus controller: decodes chip selects, holds the target
// address through the access, inserts per-region wait states and returns
// the selected read data with a one-cycle cpu_rdy pulse.
module mem_bus_ctrl
    import mem_map_pkg::*;
#(
    parameter int unsigned RAM_WAIT = 0,
    parameter int unsigned ROM_WAIT = 0,
    parameter int unsigned PIA_WAIT = 0,
    parameter int unsigned BASIC_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_valid,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_rdy,
    output logic [7:0]  cpu_din,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        ram_cs,
    output logic        woz_cs,
    output logic        basic_cs,
    output logic        pia_cs,
    output logic        ram_we,
    output logic        pia_we,
    input  logic [7:0]  ram_dout,
    input  logic [7:0]  woz_dout,
    input  logic [7:0]  basic_dout,
    input  logic [7:0]  pia_dout
);

    if (RAM_WAIT > WAIT_MAX || ROM_WAIT > WAIT_MAX || PIA_WAIT > WAIT_MAX) begin : g_bad_wait
        $error("mem_bus_ctrl: RAM_WAIT/ROM_WAIT/PIA_WAIT must be in 0..15");
    end

    localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);
    localparam logic [3:0] ROM_WAIT_C = 4'(ROM_WAIT);
    localparam logic [3:0] PIA_WAIT_C = 4'(PIA_WAIT);

    state_t      state_q;
    logic [3:0]  cnt_q;
    region_t     sel_q;
    logic        we_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;

    region_t     dec_region;
    region_t     act_region;
    logic [3:0]  dec_wait;
    logic        resp;

    function automatic logic [3:0] region_wait(input region_t r);
        case (r)
            RAM:        return RAM_WAIT_C;
            PIA:        return PIA_WAIT_C;
            BASIC, WOZ: return ROM_WAIT_C;
            default:    return 4'd0;
        endcase
    endfunction

    mem_addr_decode #(
        .BASIC_EN (BASIC_EN != 0)
    ) u_decode (
        .cpu_addr (cpu_addr),
        .region   (dec_region)
    );

    assign dec_wait = region_wait(dec_region);

    // Access sequencer: accept in IDLE, count wait states, pulse RESP once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= NONE;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_valid) begin
                        sel_q   <= dec_region;
                        we_q    <= cpu_we;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        cnt_q   <= dec_wait;
                        state_q <= (dec_wait == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Chip selects follow the live decode while idle so the target samples
    // the address on the accept edge; afterwards they come from the latch.
    // The live path is masked by rst so reset clears outputs immediately.
    always_comb begin
        act_region = sel_q;
        if (state_q == IDLE) begin
            act_region = cpu_valid ? dec_region : NONE;
        end
    end

    assign ram_cs   = !rst && (act_region == RAM);
    assign woz_cs   = !rst && (act_region == WOZ);
    assign basic_cs = !rst && (act_region == BASIC);
    assign pia_cs   = !rst && (act_region == PIA);
    assign mem_addr = rst ? 16'h0000 : ((state_q == IDLE) ? cpu_addr : addr_q);

    assign resp      = (state_q == RESP);
    assign cpu_rdy   = resp;
    assign mem_wdata = wdata_q;
    assign ram_we    = resp && we_q && (sel_q == RAM);
    assign pia_we    = resp && we_q && (sel_q == PIA);

    // Read-data return: only meaningful during the RESP pulse of a read
    always_comb begin
        cpu_din = 8'h00;
        if (resp && !we_q) begin
            case (sel_q)
                RAM:     cpu_din = ram_dout;
                PIA:     cpu_din = pia_dout;
                BASIC:   cpu_din = basic_dout;
                WOZ:     cpu_din = woz_dout;
                default: cpu_din = OPEN_BUS_DATA;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl. Two instances share the CPU-side inputs:
// u_a uses default parameters, u_b uses RAM_WAIT=3, ROM_WAIT=2, PIA_WAIT=1
// and BASIC_EN=0.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_valid;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic [7:0]  ram_dout, woz_dout, basic_dout, pia_dout;

    logic        rdy_a, ram_cs_a, woz_cs_a, basic_cs_a, pia_cs_a, ram_we_a, pia_we_a;
    logic [7:0]  din_a, mwd_a;
    logic [15:0] maddr_a;
    logic        rdy_b, ram_cs_b, woz_cs_b, basic_cs_b, pia_cs_b, ram_we_b, pia_we_b;
    logic [7:0]  din_b, mwd_b;
    logic [15:0] maddr_b;

    wire [3:0]  cs4_a  = {ram_cs_a, woz_cs_a, basic_cs_a, pia_cs_a};
    wire [3:0]  cs4_b  = {ram_cs_b, woz_cs_b, basic_cs_b, pia_cs_b};
    wire [1:0]  we2_a  = {ram_we_a, pia_we_a};
    wire [38:0] all_a  = {rdy_a, din_a, maddr_a, mwd_a, cs4_a, we2_a};
    wire [38:0] all_b  = {rdy_b, din_b, maddr_b, mwd_b, cs4_b, ram_we_b, pia_we_b};

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl u_a (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_valid(cpu_valid),
        .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdy(rdy_a), .cpu_din(din_a),
        .mem_addr(maddr_a), .mem_wdata(mwd_a), .ram_cs(ram_cs_a), .woz_cs(woz_cs_a),
        .basic_cs(basic_cs_a), .pia_cs(pia_cs_a), .ram_we(ram_we_a), .pia_we(pia_we_a),
        .ram_dout(ram_dout), .woz_dout(woz_dout), .basic_dout(basic_dout), .pia_dout(pia_dout)
    );

    mem_bus_ctrl #(
        .RAM_WAIT(3), .ROM_WAIT(2), .PIA_WAIT(1), .BASIC_EN(0)
    ) u_b (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_valid(cpu_valid),
        .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdy(rdy_b), .cpu_din(din_b),
        .mem_addr(maddr_b), .mem_wdata(mwd_b), .ram_cs(ram_cs_b), .woz_cs(woz_cs_b),
        .basic_cs(basic_cs_b), .pia_cs(pia_cs_b), .ram_we(ram_we_b), .pia_we(pia_we_b),
        .ram_dout(ram_dout), .woz_dout(woz_dout), .basic_dout(basic_dout), .pia_dout(pia_dout)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cpu_valid = 1'b0;
        cpu_we    = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (all_a !== 39'd0) $display("FAIL reset_init_a: got %h want 0", all_a);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        step();
        // Start a RAM write so outputs are non-zero, then reset asynchronously
        cpu_addr = 16'h0010; cpu_we = 1'b1; cpu_wdata = 8'hAA; cpu_valid = 1'b1;
        step();
        total++;
        if (ram_we_a !== 1'b1) $display("FAIL reset_pre_we_a: got %b want 1", ram_we_a);
        else passed++;
        #1 rst = 1'b1;
        #1;
        total++;
        if (all_a !== 39'd0) $display("FAIL reset_async_a: got %h want 0", all_a);
        else passed++;
        total++;
        if (all_b !== 39'd0) $display("FAIL reset_async_b: got %h want 0", all_b);
        else passed++;
        cpu_valid = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            total++;
            if ({rdy_a, rdy_b} !== 2'b00) $display("FAIL reset_idle_rdy%0d: got %b want 00", k, {rdy_a, rdy_b});
            else passed++;
        end
        step();
    endtask

    task automatic test_reads;
        logic [15:0] addrs [4] = '{16'hFFFF, 16'h1FFF, 16'hD012, 16'hE123};
        logic [3:0]  cs_exp[4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [7:0]  d_exp [4] = '{8'hFF, 8'h3C, 8'h77, 8'h42};
        woz_dout = 8'hFF; ram_dout = 8'h3C; pia_dout = 8'h77; basic_dout = 8'h42;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = addrs[i]; cpu_we = 1'b0; cpu_valid = 1'b1;
            @(negedge clk);
            total++;
            if ({cs4_a, rdy_a, maddr_a} !== {cs_exp[i], 1'b0, addrs[i]})
                $display("FAIL read%0d_T0: cs/rdy/addr got %b/%b/%h want %b/0/%h", i, cs4_a, rdy_a, maddr_a, cs_exp[i], addrs[i]);
            else passed++;
            step();
            @(negedge clk);
            total++;
            if ({cs4_a, rdy_a, din_a} !== {cs_exp[i], 1'b1, d_exp[i]})
                $display("FAIL read%0d_T1: cs/rdy/din got %b/%b/%h want %b/1/%h", i, cs4_a, rdy_a, din_a, cs_exp[i], d_exp[i]);
            else passed++;
            cpu_valid = 1'b0;
            step();
            @(negedge clk);
            total++;
            if ({cs4_a, rdy_a, din_a} !== 13'd0)
                $display("FAIL read%0d_T2: cs/rdy/din got %b/%b/%h want 0/0/00", i, cs4_a, rdy_a, din_a);
            else passed++;
            step();
        end
        idle(8);
    endtask

    task automatic test_wait_states;
        cpu_addr = 16'hFF00; cpu_we = 1'b0; woz_dout = 8'hD8; cpu_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if ({cs4_b, maddr_b, rdy_b, din_b} !== {4'b0100, 16'hFF00, (k == 3), ((k == 3) ? 8'hD8 : 8'h00)})
                $display("FAIL wait_T%0d: cs/addr/rdy/din got %b/%h/%b/%h want 0100/ff00/%0d/%h",
                         k, cs4_b, maddr_b, rdy_b, din_b, (k == 3), ((k == 3) ? 8'hD8 : 8'h00));
            else passed++;
            if (k == 3) cpu_valid = 1'b0;
            step();
        end
        @(negedge clk);
        total++;
        if ({rdy_b, cs4_b} !== 5'd0) $display("FAIL wait_after: rdy/cs got %b/%b want 0/0000", rdy_b, cs4_b);
        else passed++;
        idle(8);
    endtask

    task automatic test_writes;
        int pulses = 0;
        logic [15:0] addrs [3] = '{16'hD011, 16'hFFF0, 16'h8000};
        logic [1:0]  we_exp[3] = '{2'b01, 2'b00, 2'b00};
        // RAM write with cpu_valid held four cycles: two accepted accesses
        cpu_addr = 16'h0300; cpu_wdata = 8'h5A; cpu_we = 1'b1; cpu_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ram_we_a) pulses++;
            total++;
            if ({ram_cs_a, we2_a, rdy_a} !== {1'b1, k[0], 1'b0, k[0]})
                $display("FAIL ramwr_T%0d: cs/we/rdy got %b/%b/%b want 1/%b0/%b", k, ram_cs_a, we2_a, rdy_a, k[0], k[0]);
            else passed++;
            if (k[0]) begin
                total++;
                if (mwd_a !== 8'h5A) $display("FAIL ramwr_wdata_T%0d: got %h want 5a", k, mwd_a);
                else passed++;
            end
            step();
        end
        cpu_valid = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        if (ram_we_a) pulses++;
        total++;
        if (pulses !== 2) $display("FAIL ramwr_pulses: got %0d want 2", pulses);
        else passed++;
        step();
        // Single-cycle writes to PIA, WOZ (dropped) and unmapped (dropped)
        for (int i = 0; i < 3; i++) begin
            cpu_addr = addrs[i]; cpu_wdata = 8'h81 + 8'(i); cpu_we = 1'b1; cpu_valid = 1'b1;
            @(negedge clk);
            total++;
            if (we2_a !== 2'b00) $display("FAIL wr%0d_T0_we: got %b want 00", i, we2_a);
            else passed++;
            step();
            @(negedge clk);
            total++;
            if ({we2_a, rdy_a, din_a, mwd_a} !== {we_exp[i], 1'b1, 8'h00, 8'h81 + 8'(i)})
                $display("FAIL wr%0d_T1: we/rdy/din/wdata got %b/%b/%h/%h want %b/1/00/%h",
                         i, we2_a, rdy_a, din_a, mwd_a, we_exp[i], 8'h81 + 8'(i));
            else passed++;
            cpu_valid = 1'b0; cpu_we = 1'b0;
            step();
        end
        idle(8);
    endtask

    task automatic test_unmapped;
        basic_dout = 8'h42;
        cpu_addr = 16'h8000; cpu_we = 1'b0; cpu_valid = 1'b1;
        @(negedge clk);
        total++;
        if ({cs4_a, cs4_b} !== 8'd0) $display("FAIL unm8000_T0_cs: got %b/%b want 0000/0000", cs4_a, cs4_b);
        else passed++;
        step();
        @(negedge clk);
        total++;
        if ({cs4_a, rdy_a, din_a, rdy_b, din_b} !== {4'b0000, 1'b1, 8'hFF, 1'b1, 8'hFF})
            $display("FAIL unm8000_T1: a cs/rdy/din %b/%b/%h b rdy/din %b/%h want 0000/1/ff 1/ff",
                     cs4_a, rdy_a, din_a, rdy_b, din_b);
        else passed++;
        cpu_valid = 1'b0;
        step();
        step();
        cpu_addr = 16'hE000; cpu_valid = 1'b1;
        @(negedge clk);
        total++;
        if ({cs4_a, cs4_b} !== {4'b0010, 4'b0000}) $display("FAIL unmE000_T0_cs: got %b/%b want 0010/0000", cs4_a, cs4_b);
        else passed++;
        step();
        @(negedge clk);
        total++;
        if ({basic_cs_b, rdy_b, din_b, din_a} !== {1'b0, 1'b1, 8'hFF, 8'h42})
            $display("FAIL unmE000_T1: b cs/rdy/din %b/%b/%h a din %h want 0/1/ff 42", basic_cs_b, rdy_b, din_b, din_a);
        else passed++;
        cpu_valid = 1'b0;
        idle(8);
    endtask

    task automatic test_reset_mid_access;
        cpu_addr = 16'h0010; cpu_wdata = 8'h99; cpu_we = 1'b1; cpu_valid = 1'b1;
        @(negedge clk);
        total++;
        if (ram_cs_b !== 1'b1) $display("FAIL rstmid_T0_cs: got %b want 1", ram_cs_b);
        else passed++;
        step();
        step();
        #1 rst = 1'b1;
        cpu_valid = 1'b0; cpu_we = 1'b0;
        #1;
        total++;
        if (all_b !== 39'd0) $display("FAIL rstmid_async_b: got %h want 0", all_b);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clk);
            total++;
            if (ram_we_b !== 1'b0) $display("FAIL rstmid_we%0d: got %b want 0", k, ram_we_b);
            else passed++;
        end
        step();
        // Fresh read after reset takes the full RAM_WAIT=3 latency
        cpu_addr = 16'h0010; cpu_we = 1'b0; ram_dout = 8'h6E; cpu_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if ({ram_cs_b, rdy_b, din_b} !== {1'b1, (k == 4), ((k == 4) ? 8'h6E : 8'h00)})
                $display("FAIL rstmid_rd_T%0d: cs/rdy/din got %b/%b/%h want 1/%0d/%h",
                         k, ram_cs_b, rdy_b, din_b, (k == 4), ((k == 4) ? 8'h6E : 8'h00));
            else passed++;
            if (k == 4) cpu_valid = 1'b0;
            step();
        end
        idle(4);
    endtask

    initial begin
        rst = 1'b1;
        cpu_addr = 16'hFFFF; cpu_valid = 1'b0; cpu_we = 1'b0; cpu_wdata = 8'h00;
        ram_dout = 8'h00; woz_dout = 8'h00; basic_dout = 8'h00; pia_dout = 8'h00;
        test_reset();
        test_reads();
        test_wait_states();
        test_writes();
        test_unmapped();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
